// File: rtl/wb_reg_timeout.sv
// Registered Wishbone master->slave slice with watchdog; 1 cycle each way, request to slave and response to master.
// A slave left unanswered for TIMEOUT cycles gets aborted and the master sees ERR; master CYC drop aborts the slave side.
module wb_reg_timeout #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_WIDTH    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [DATA_WIDTH-1:0]   m_dat_i,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    input  logic                    m_we_i,
    input  logic [SELECT_WIDTH-1:0] m_sel_i,
    input  logic                    m_stb_i,
    output logic                    m_ack_o,
    output logic                    m_err_o,
    output logic                    m_rty_o,
    input  logic                    m_cyc_i,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic                    s_we_o,
    output logic [SELECT_WIDTH-1:0] s_sel_o,
    output logic                    s_stb_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    output logic                    s_cyc_o,
    output logic                    timeout_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RESP} state_t;

    localparam logic [CNT_WIDTH-1:0] LP_LAST = (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

    state_t                  r_state, w_state;
    logic [CNT_WIDTH-1:0]    r_cnt, w_cnt;
    logic [DATA_WIDTH-1:0]   r_m_dat, w_m_dat;
    logic                    r_m_ack, w_m_ack;
    logic                    r_m_err, w_m_err;
    logic                    r_m_rty, w_m_rty;
    logic [ADDR_WIDTH-1:0]   r_s_adr, w_s_adr;
    logic [DATA_WIDTH-1:0]   r_s_dat, w_s_dat;
    logic                    r_s_we, w_s_we;
    logic [SELECT_WIDTH-1:0] r_s_sel, w_s_sel;
    logic                    r_s_stb, w_s_stb;
    logic                    r_s_cyc, w_s_cyc;
    logic                    r_timeout, w_timeout;
    logic                    r_to_flag, w_to_flag;
    logic                    w_expire;
    logic                    w_slv_resp;

    assign w_expire   = (TIMEOUT != 0) && (r_cnt == LP_LAST);
    assign w_slv_resp = s_ack_i || s_err_i || s_rty_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_m_dat   <= '0;
            r_m_ack   <= 1'b0;
            r_m_err   <= 1'b0;
            r_m_rty   <= 1'b0;
            r_s_adr   <= '0;
            r_s_dat   <= '0;
            r_s_we    <= 1'b0;
            r_s_sel   <= '0;
            r_s_stb   <= 1'b0;
            r_s_cyc   <= 1'b0;
            r_timeout <= 1'b0;
            r_to_flag <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_m_dat   <= w_m_dat;
            r_m_ack   <= w_m_ack;
            r_m_err   <= w_m_err;
            r_m_rty   <= w_m_rty;
            r_s_adr   <= w_s_adr;
            r_s_dat   <= w_s_dat;
            r_s_we    <= w_s_we;
            r_s_sel   <= w_s_sel;
            r_s_stb   <= w_s_stb;
            r_s_cyc   <= w_s_cyc;
            r_timeout <= w_timeout;
            r_to_flag <= w_to_flag;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_m_dat   = '0;
        w_m_ack   = 1'b0;
        w_m_err   = 1'b0;
        w_m_rty   = 1'b0;
        w_s_adr   = r_s_adr;
        w_s_dat   = r_s_dat;
        w_s_we    = r_s_we;
        w_s_sel   = r_s_sel;
        w_s_stb   = r_s_stb;
        w_s_cyc   = r_s_cyc;
        w_timeout = 1'b0;
        w_to_flag = r_to_flag;
        case (r_state)
            S_IDLE: begin
                w_s_adr = m_adr_i;
                w_s_dat = m_dat_i;
                w_s_we  = m_we_i;
                w_s_sel = m_sel_i;
                w_s_cyc = m_cyc_i;
                w_s_stb = 1'b0;
                if (m_cyc_i && m_stb_i) begin
                    w_s_stb = 1'b1;
                    w_cnt   = '0;
                    w_state = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                w_cnt = r_cnt + CNT_WIDTH'(1);
                if (!m_cyc_i) begin
                    w_s_cyc = 1'b0;
                    w_s_stb = 1'b0;
                    w_s_we  = 1'b0;
                    w_state = S_IDLE;
                end else if (w_slv_resp) begin
                    // err beats rty beats ack so the master sees exactly one strobe
                    w_m_dat   = s_dat_i;
                    w_m_err   = s_err_i;
                    w_m_rty   = !s_err_i && s_rty_i;
                    w_m_ack   = !s_err_i && !s_rty_i && s_ack_i;
                    w_s_stb   = 1'b0;
                    w_s_we    = 1'b0;
                    w_to_flag = 1'b0;
                    w_state   = S_RESP;
                end else if (w_expire) begin
                    w_m_err   = 1'b1;
                    w_timeout = 1'b1;
                    w_s_cyc   = 1'b0;
                    w_s_stb   = 1'b0;
                    w_s_we    = 1'b0;
                    w_to_flag = 1'b1;
                    w_state   = S_RESP;
                end
            end
            S_RESP: begin
                // a timed-out slave stays released; otherwise follow CYC to keep block cycles open
                w_s_stb = 1'b0;
                w_s_cyc = r_to_flag ? 1'b0 : m_cyc_i;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign m_dat_o   = r_m_dat;
    assign m_ack_o   = r_m_ack;
    assign m_err_o   = r_m_err;
    assign m_rty_o   = r_m_rty;
    assign s_adr_o   = r_s_adr;
    assign s_dat_o   = r_s_dat;
    assign s_we_o    = r_s_we;
    assign s_sel_o   = r_s_sel;
    assign s_stb_o   = r_s_stb;
    assign s_cyc_o   = r_s_cyc;
    assign timeout_o = r_timeout;
    assign busy_o    = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_wb_reg_timeout.sv
// Bench for wb_reg_timeout with a 16-cycle watchdog: vector table, corner sequences, randomized transactions.
module tb_wb_reg_timeout;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic [31:0] m_adr_i, m_dat_i, m_dat_o;
    logic        m_we_i;
    logic [3:0]  m_sel_i;
    logic        m_stb_i, m_ack_o, m_err_o, m_rty_o, m_cyc_i;
    logic [31:0] s_adr_o, s_dat_i, s_dat_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic        s_stb_o, s_ack_i, s_err_i, s_rty_i, s_cyc_o;
    logic        timeout_o, busy_o;

    int checks   = 0;
    int failures = 0;

    wb_reg_timeout #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
        .m_we_i(m_we_i), .m_sel_i(m_sel_i), .m_stb_i(m_stb_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_cyc_i(m_cyc_i),
        .s_adr_o(s_adr_o), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
        .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_cyc_o(s_cyc_o),
        .timeout_o(timeout_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int          delay;   // ACTIVE cycle in which the slave answers
        logic [2:0]  resp;    // {err, rty, ack}; 0 = silent slave
        logic        hold;    // master keeps CYC during the response cycle
        logic        e_ack;
        logic        e_err;
        logic        e_rty;
        logic        e_to;
        int          e_lat;   // edges from s_stb_o rising to the master strobe
        logic [31:0] e_dat;
    } vec_t;

    typedef struct {
        logic        ack;
        logic        err;
        logic        rty;
        logic        to;
        int          lat;
        logic [31:0] dat;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectation: an answer inside the window wins, otherwise the watchdog closes it.
    function automatic exp_t model(input int delay, input logic [2:0] resp, input logic [31:0] rdata);
        exp_t e;
        if (resp != 3'b000 && delay < TO) begin
            e.lat = delay + 1;
            e.err = resp[2];
            e.rty = !resp[2] && resp[1];
            e.ack = (resp == 3'b001);
            e.to  = 1'b0;
            e.dat = rdata;
        end else begin
            e.lat = TO;
            e.err = 1'b1;
            e.rty = 1'b0;
            e.ack = 1'b0;
            e.to  = 1'b1;
            e.dat = 32'h0;
        end
        return e;
    endfunction

    task automatic do_xfer(input vec_t v, input string tag);
        m_adr_i = v.adr;
        m_dat_i = v.dat;
        m_we_i  = v.we;
        m_sel_i = v.sel;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        s_dat_i = v.rdata;
        tick();
        chk({tag, "_req_adr_dat"}, {s_adr_o, s_dat_o}, {v.adr, v.dat});
        chk({tag, "_req_ctl"}, 64'({s_we_o, s_sel_o, s_stb_o, s_cyc_o, busy_o}),
            64'({v.we, v.sel, 1'b1, 1'b1, 1'b1}));
        for (int n = 0; n < v.e_lat; n++) begin
            if (n == v.delay) begin
                s_ack_i = v.resp[0];
                s_rty_i = v.resp[1];
                s_err_i = v.resp[2];
            end
            tick();
            s_ack_i = 1'b0;
            s_rty_i = 1'b0;
            s_err_i = 1'b0;
            if (n < v.e_lat - 1)
                chk({tag, "_wait_quiet"}, 64'({m_ack_o, m_err_o, m_rty_o, timeout_o, s_stb_o}),
                    64'({4'b0000, 1'b1}));
        end
        chk({tag, "_resp_strobes"}, 64'({m_ack_o, m_err_o, m_rty_o, timeout_o}),
            64'({v.e_ack, v.e_err, v.e_rty, v.e_to}));
        chk({tag, "_resp_dat"}, 64'(m_dat_o), 64'(v.e_dat));
        chk({tag, "_resp_slave"}, 64'({s_stb_o, s_we_o, s_cyc_o, busy_o}),
            64'({1'b0, 1'b0, !v.e_to, 1'b0}));
        m_stb_i = 1'b0;
        m_cyc_i = v.hold;
        tick();
        chk({tag, "_post_master"}, 64'({m_dat_o, m_ack_o, m_err_o, m_rty_o, timeout_o}), 64'h0);
        chk({tag, "_post_cyc"}, 64'({s_cyc_o, s_stb_o}), 64'({v.hold && !v.e_to, 1'b0}));
        m_cyc_i = 1'b0;
        tick();
        chk({tag, "_idle_cyc"}, 64'({s_cyc_o, s_stb_o, busy_o}), 64'h0);
    endtask

    vec_t vecs[8];
    vec_t rv;
    exp_t e;

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        3,  3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4,  32'h0};
        vecs[1] = '{1'b0, 32'h20, 32'h0,        4'hF, 32'h12345678, 0,  3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,  32'h12345678};
        vecs[2] = '{1'b0, 32'h30, 32'h0,        4'h3, 32'hCAFEF00D, 0,  3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16, 32'h0};
        vecs[3] = '{1'b0, 32'h40, 32'h0,        4'hF, 32'hA5A5A5A5, 2,  3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3,  32'hA5A5A5A5};
        vecs[4] = '{1'b0, 32'h50, 32'h0,        4'hF, 32'h0BADCAFE, 15, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16, 32'h0BADCAFE};
        vecs[5] = '{1'b1, 32'h60, 32'h11112222, 4'hC, 32'h33334444, 16, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16, 32'h0};
        vecs[6] = '{1'b0, 32'h70, 32'h0,        4'h1, 32'h55AA55AA, 1,  3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2,  32'h55AA55AA};
        vecs[7] = '{1'b1, 32'h80, 32'h9,        4'hF, 32'h77,       5,  3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6,  32'h77};

        rst = 1'b1;
        m_adr_i = '0; m_dat_i = '0; m_we_i = 1'b0; m_sel_i = '0;
        m_stb_i = 1'b0; m_cyc_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_master", 64'({m_dat_o, m_ack_o, m_err_o, m_rty_o}), 64'h0);
        chk("reset_slave_ctl", 64'({s_we_o, s_sel_o, s_stb_o, s_cyc_o, timeout_o, busy_o}), 64'h0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) do_xfer(vecs[i], $sformatf("vec%0d", i));

        // master abandons the cycle while the slave is still thinking
        m_adr_i = 32'h44; m_dat_i = 32'hFEEDFACE; m_we_i = 1'b1; m_sel_i = 4'hF;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        chk("abort_started", 64'({s_stb_o, s_cyc_o, busy_o}), 64'h7);
        tick();
        tick();
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        tick();
        chk("abort_slave", 64'({s_cyc_o, s_stb_o, s_we_o, busy_o}), 64'h0);
        chk("abort_no_resp", 64'({m_ack_o, m_err_o, m_rty_o, timeout_o}), 64'h0);
        tick();
        chk("abort_quiet", 64'({m_ack_o, m_err_o, m_rty_o, timeout_o, s_cyc_o}), 64'h0);
        do_xfer(vecs[0], "after_abort");

        // asynchronous reset in the middle of an active transfer
        m_adr_i = 32'h10; m_dat_i = 32'hDEADBEEF; m_we_i = 1'b1; m_sel_i = 4'hF;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_master", 64'({m_dat_o, m_ack_o, m_err_o, m_rty_o}), 64'h0);
        chk("arst_slave_adr_dat", {s_adr_o, s_dat_o}, 64'h0);
        chk("arst_slave_ctl", 64'({s_we_o, s_sel_o, s_stb_o, s_cyc_o, timeout_o, busy_o}), 64'h0);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        tick();
        #3;
        rst = 1'b0;
        tick();
        do_xfer(vecs[0], "after_arst");

        for (int k = 0; k < 40; k++) begin
            rv.we    = 1'($urandom_range(0, 1));
            rv.adr   = $urandom;
            rv.dat   = $urandom;
            rv.sel   = 4'($urandom_range(0, 15));
            rv.rdata = $urandom;
            rv.delay = $urandom_range(0, 20);
            rv.resp  = 3'($urandom_range(0, 7));
            rv.hold  = 1'($urandom_range(0, 1));
            e = model(rv.delay, rv.resp, rv.rdata);
            rv.e_ack = e.ack;
            rv.e_err = e.err;
            rv.e_rty = e.rty;
            rv.e_to  = e.to;
            rv.e_lat = e.lat;
            rv.e_dat = e.dat;
            do_xfer(rv, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
